lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 195 +++++++++++++++++++
 tb/tb_lsu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: accepts one RV32I memory request at a time from the
// execute stage, drives a word-aligned read or write toward the memory
// arbiter, and returns sign/zero-extended load results on a one-cycle pulse.
// Misaligned or illegal width codes are reported as a one-cycle fault
// without touching memory.
module lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_stall,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_is_store,
  input  logic [2:0]    i_funct3,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic [4:0]    i_rd,
  output logic          o_lsu_read,
  output logic [AW-1:0] o_r_lsu_addr,
  input  logic [DW-1:0] i_r_lsu_data,
  input  logic          i_lsu_ack,
  output logic          o_lsu_write,
  output logic [AW-1:0] o_w_lsu_addr,
  output logic [3:0]    o_w_lsu_byte_en,
  output logic [DW-1:0] o_w_lsu_data,
  output logic          o_wb_valid,
  output logic [4:0]    o_wb_rd,
  output logic [DW-1:0] o_wb_data,
  output logic          o_fault,
  output logic [AW-1:0] o_fault_addr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_funct3;
  logic [DW-1:0] r_wdata;
  logic [4:0]    r_rd;
  logic          r_wb_valid;
  logic [4:0]    r_wb_rd;
  logic [DW-1:0] r_wb_data;
  logic          r_fault;
  logic [AW-1:0] r_fault_addr;
  logic          w_req_fault;
  logic          w_accept;

  // Illegal width code or an address not aligned to the access size.
  function automatic logic access_fault(input logic st, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic f;
    f = 1'b0;
    if (st) begin
      case (f3)
        3'd0:    f = 1'b0;
        3'd1:    f = a[0];
        3'd2:    f = (a != 2'b00);
        default: f = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: f = 1'b0;
        3'd1, 3'd5: f = a[0];
        3'd2:       f = (a != 2'b00);
        default:    f = 1'b1;
      endcase
    end
    return f;
  endfunction

  // Pick the addressed lane out of the memory word and extend it.
  function automatic logic [DW-1:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [DW-1:0] w);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Byte-lane enables for a store of the given width at the given offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      3'd0:    be = 4'b0001 << a;
      3'd1:    be = 4'b0011 << a;
      default: be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicate narrow store data across all lanes so the enables pick it out.
  function automatic logic [DW-1:0] store_data(input logic [2:0] f3,
                                               input logic [DW-1:0] w);
    logic [DW-1:0] d;
    case (f3)
      3'd0:    d = {4{w[7:0]}};
      3'd1:    d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  assign o_ready     = (r_state == S_IDLE);
  assign w_accept    = i_valid && o_ready;
  assign w_req_fault = access_fault(i_is_store, i_funct3, i_addr[1:0]);

  // Next-state logic: faulting requests never leave IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_req_fault) w_next = i_is_store ? S_WRITE : S_READ;
      end
      S_READ: begin
        if (i_lsu_ack) w_next = S_IDLE;
      end
      S_WRITE: begin
        if (!i_stall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, frozen while the clock enable is low.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else if (i_clk_en) r_state <= w_next;
  end

  // Request capture, fault pulse and load write-back registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_rd         <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (i_clk_en) begin
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      if (w_accept) begin
        if (w_req_fault) begin
          r_fault      <= 1'b1;
          r_fault_addr <= i_addr;
        end else begin
          r_addr   <= i_addr;
          r_funct3 <= i_funct3;
          r_wdata  <= i_wdata;
          r_rd     <= i_rd;
        end
      end
      if (r_state == S_READ && i_lsu_ack) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= load_extend(r_funct3, r_addr[1:0], i_r_lsu_data);
      end
    end
  end

  assign o_lsu_read      = (r_state == S_READ);
  assign o_r_lsu_addr    = {r_addr[AW-1:2], 2'b00};
  assign o_lsu_write     = (r_state == S_WRITE);
  assign o_w_lsu_addr    = {r_addr[AW-1:2], 2'b00};
  assign o_w_lsu_byte_en = o_lsu_write ? store_be(r_funct3, r_addr[1:0]) : 4'b0000;
  assign o_w_lsu_data    = o_lsu_write ? store_data(r_funct3, r_wdata) : '0;
  assign o_wb_valid      = r_wb_valid;
  assign o_wb_rd         = r_wb_rd;
  assign o_wb_data       = r_wb_data;
  assign o_fault         = r_fault;
  assign o_fault_addr    = r_fault_addr;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU: stimulus tasks push expected reads, writes,
// write-backs and faults into queues; a monitor pops and compares them
// whenever the DUT presents the corresponding output.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        stall = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rd = '0;
  logic        lsu_read;
  logic [31:0] raddr;
  logic [31:0] rdata = '0;
  logic        ack = 1'b0;
  logic        lsu_write;
  logic [31:0] waddr;
  logic [3:0]  be;
  logic [31:0] wdata_o;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [31:0] fault_addr;

  lsu #(.AW(32), .DW(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall),
    .i_valid(valid), .o_ready(ready), .i_is_store(is_store), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .i_rd(rd),
    .o_lsu_read(lsu_read), .o_r_lsu_addr(raddr), .i_r_lsu_data(rdata),
    .i_lsu_ack(ack), .o_lsu_write(lsu_write), .o_w_lsu_addr(waddr),
    .o_w_lsu_byte_en(be), .o_w_lsu_data(wdata_o),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_fault(fault), .o_fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [4:0] rd; } wb_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;

  wb_t         wb_q[$];
  wr_t         wr_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] flt_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT output with no expected entry queued", name);
  endtask

  // Monitor: evaluates once per enabled edge, just after it.
  logic mon_en, mon_rst;
  logic prev_r = 1'b0, prev_w = 1'b0;
  always @(posedge clk) begin
    mon_en  = clk_en;
    mon_rst = rst;
    #1;
    if (mon_en && mon_rst) begin
      if (wb_valid) begin
        if (wb_q.size() == 0) unexpected("wb_pulse");
        else begin
          wb_t e;
          e = wb_q.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        end
      end
      if (fault) begin
        if (flt_q.size() == 0) unexpected("fault_pulse");
        else chk("fault_addr", fault_addr, flt_q.pop_front());
      end
      if (lsu_read && !prev_r) begin
        if (rd_q.size() == 0) unexpected("read_req");
        else chk("read_addr", raddr, rd_q.pop_front());
      end
      if (lsu_write && !prev_w) begin
        if (wr_q.size() == 0) unexpected("write_req");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("write_addr", waddr, w.addr);
          chk("write_be", {28'd0, be}, {28'd0, w.be});
          chk("write_data", wdata_o, w.data);
        end
      end
      prev_r = lsu_read;
      prev_w = lsu_write;
    end
    if (!rst) begin
      prev_r = 1'b0;
      prev_w = 1'b0;
    end
  end

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                         input logic [31:0] word, input int dly,
                         input logic [31:0] exp_raddr, input logic [31:0] exp_data);
    @(negedge clk);
    valid = 1'b1; is_store = 1'b0; funct3 = f3; addr = a; rd = r;
    rd_q.push_back(exp_raddr);
    wb_q.push_back('{exp_data, r});
    @(negedge clk);
    valid = 1'b0;
    repeat (dly) @(negedge clk);
    ack = 1'b1; rdata = word;
    @(negedge clk);
    ack = 1'b0;
    chk("ready_after_load", {31'd0, ready}, 32'd1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int n_stall, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
    int held;
    @(negedge clk);
    valid = 1'b1; is_store = 1'b1; funct3 = f3; addr = a; wdata = d;
    wr_q.push_back('{exp_addr, exp_be, exp_data});
    @(negedge clk);
    valid = 1'b0;
    held = 0;
    for (int k = 0; k < 20; k++) begin
      if (!lsu_write) break;
      stall = (held < n_stall);
      held++;
      @(negedge clk);
    end
    stall = 1'b0;
    chk("write_hold_cycles", held, n_stall + 1);
    chk("ready_after_store", {31'd0, ready}, 32'd1);
  endtask

  task automatic do_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    valid = 1'b1; is_store = st; funct3 = f3; addr = a;
    flt_q.push_back(a);
    @(negedge clk);
    valid = 1'b0;
    chk("fault_ready", {31'd0, ready}, 32'd1);
    chk("fault_no_read", {31'd0, lsu_read}, 32'd0);
    chk("fault_no_write", {31'd0, lsu_write}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_read", {31'd0, lsu_read}, 32'd0);
    chk("rst_write", {31'd0, lsu_write}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_be", {28'd0, be}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_raddr", raddr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b1;

    // Loads
    do_load(3'd0, 32'h103, 5'd1, 32'h80FF_1234, 0, 32'h100, 32'hFFFF_FF80);
    do_load(3'd5, 32'h202, 5'd2, 32'hBEEF_0001, 0, 32'h200, 32'h0000_BEEF);
    do_load(3'd1, 32'h202, 5'd3, 32'hBEEF_0001, 2, 32'h200, 32'hFFFF_BEEF);
    do_load(3'd2, 32'h404, 5'd4, 32'hDEAD_BEEF, 1, 32'h404, 32'hDEAD_BEEF);
    do_load(3'd4, 32'h001, 5'd5, 32'h1234_5678, 0, 32'h000, 32'h0000_0056);
    do_load(3'd1, 32'h200, 5'd6, 32'h1234_7FFF, 0, 32'h200, 32'h0000_7FFF);
    do_load(3'd4, 32'h002, 5'd0, 32'h00AB_0000, 0, 32'h000, 32'h0000_00AB);

    // Stores
    do_store(3'd0, 32'h301, 32'h1234_56AB, 3, 32'h300, 4'b0010, 32'hABAB_ABAB);
    do_store(3'd1, 32'h302, 32'hCAFE_BEEF, 0, 32'h300, 4'b1100, 32'hBEEF_BEEF);
    do_store(3'd2, 32'h304, 32'h1122_3344, 1, 32'h304, 4'b1111, 32'h1122_3344);

    // Faults
    do_fault(1'b0, 3'd2, 32'h402);
    do_fault(1'b0, 3'd1, 32'h101);
    do_fault(1'b1, 3'd1, 32'h303);
    do_fault(1'b1, 3'd2, 32'h306);
    do_fault(1'b0, 3'd3, 32'h400);
    do_fault(1'b1, 3'd4, 32'h400);

    // Delayed ack with clock-enable toggling and a request held during READ
    @(negedge clk);
    valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h500; rd = 5'd7;
    rd_q.push_back(32'h500);
    wb_q.push_back('{32'hCAFE_F00D, 5'd7});
    @(negedge clk);
    funct3 = 3'd4; addr = 32'h601; rd = 5'd9;
    rd_q.push_back(32'h600);
    wb_q.push_back('{32'h0000_0033, 5'd9});
    for (int k = 0; k < 5; k++) begin
      clk_en = (k % 2 == 0);
      @(negedge clk);
      chk("busy_not_ready", {31'd0, ready}, 32'd0);
    end
    clk_en = 1'b1; ack = 1'b1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    ack = 1'b0; clk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wb_held_frozen", {31'd0, wb_valid}, 32'd1);
      chk("no_read_frozen", {31'd0, lsu_read}, 32'd0);
    end
    clk_en = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("second_req_read", {31'd0, lsu_read}, 32'd1);
    ack = 1'b1; rdata = 32'h1122_3344;
    @(negedge clk);
    ack = 1'b0;

    // Reset during READ
    @(negedge clk);
    valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h700; rd = 5'd3;
    rd_q.push_back(32'h700);
    @(negedge clk);
    valid = 1'b0;
    chk("read_before_rst", {31'd0, lsu_read}, 32'd1);
    #2 rst = 1'b0; ack = 1'b1; rdata = 32'h5555_AAAA;
    #1;
    chk("rst_async_read", {31'd0, lsu_read}, 32'd0);
    chk("rst_async_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

    repeat (3) @(negedge clk);
    chk("wb_q_drained", wb_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("flt_q_drained", flt_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
